// File: rtl/stream_demux1to4.sv
// One-to-four stream demultiplexer: each output owns a single registered slot,
// loaded from the input stream according to in_sel and drained independently.
module stream_demux1to4 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_sel,
  input  logic [W-1:0]   in_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data,
  output logic           busy,
  output logic [7:0]     drop_cnt
);

  logic [3:0] valid_vec;
  logic       in_xfer;
  logic [2:0] drop_add;
  logic [8:0] drop_sum;
  logic [7:0] drop_next;
  logic [7:0] drop_reg;

  // Readiness looks only at the addressed slot, so a stalled output never
  // blocks traffic headed elsewhere.
  assign in_ready = !flush && (!valid_vec[in_sel] || out_ready[in_sel]);
  assign in_xfer  = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic         load;
      logic         slot_valid_reg;
      logic [W-1:0] slot_data_reg;

      assign load = in_xfer && (in_sel == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid_reg <= 1'b0;
          slot_data_reg  <= '0;
        end else if (flush) begin
          slot_valid_reg <= 1'b0;
        end else if (load) begin
          slot_valid_reg <= 1'b1;
          slot_data_reg  <= in_data;
        end else if (out_ready[gi]) begin
          slot_valid_reg <= 1'b0;
        end
      end

      assign valid_vec[gi]        = slot_valid_reg;
      assign out_data[gi*W +: W]  = slot_data_reg;
    end
  endgenerate

  // Slots handshaking during a flush are delivered, so only stalled ones count.
  always_comb begin
    drop_add = '0;
    for (int k = 0; k < 4; k++) begin
      if (valid_vec[k] && !out_ready[k]) drop_add = drop_add + 3'd1;
    end
    drop_sum  = {1'b0, drop_reg} + {6'b0, drop_add};
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_reg <= '0;
    end else if (flush) begin
      drop_reg <= drop_next;
    end
  end

  assign out_valid = valid_vec;
  assign busy      = |valid_vec;
  assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_stream_demux1to4.sv
// Self-checking bench for stream_demux1to4: directed scenarios plus random
// traffic compared against a slot-level behavioural model.
module tb_stream_demux1to4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_valid;
  logic [7:0] m_data [4];
  int         m_drop;

  stream_demux1to4 #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ready();
    return !flush && (!m_valid[in_sel] || out_ready[in_sel]);
  endfunction

  task automatic model_clear();
    m_valid = 4'b0;
    m_drop  = 0;
    for (int k = 0; k < 4; k++) m_data[k] = 8'h00;
  endtask

  // Apply inputs just after the falling edge so they are stable for the next rise.
  task automatic drive(input logic f, input logic iv, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] ordy);
    @(negedge clk);
    flush = f; in_valid = iv; in_sel = s; in_data = d; out_ready = ordy;
    #1;
  endtask

  // Advance one rising edge and apply the transfer rules to the model.
  task automatic tick();
    logic acc;
    int   cnt;
    acc = in_valid && exp_ready();
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        cnt = 0;
        for (int k = 0; k < 4; k++) if (m_valid[k] && !out_ready[k]) cnt++;
        m_drop  = (m_drop + cnt > 255) ? 255 : m_drop + cnt;
        m_valid = 4'b0;
      end else begin
        for (int k = 0; k < 4; k++) if (out_ready[k]) m_valid[k] = 1'b0;
        if (acc) begin
          m_valid[in_sel] = 1'b1;
          m_data[in_sel]  = in_data;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    tick();
  endtask

  task automatic fill(input logic [3:0] mask, input logic [7:0] base);
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        drive(1'b0, 1'b1, 2'(k), base + 8'(k), 4'h0);
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0;
    in_data = 8'h00; out_ready = 4'h0;
    model_clear();
    #1;
    total++;
    if (out_valid !== 4'b0 || busy !== 1'b0 || drop_cnt !== 8'd0 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b busy=%b drop=%0d data=%h, required 0000/0/0/0",
               out_valid, busy, drop_cnt, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 2'd3, 8'h00, 4'h0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    drive(1'b0, 1'b1, 2'd2, 8'hA5, 4'h0);
    tick();
    total++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hA5) begin
      bad++;
      $display("FAIL single_beat: out_valid=%b data2=%h, required 0100/a5",
               out_valid, out_data[23:16]);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_set: busy=%b, required 1", busy);
    end
    drain();
    total++;
    if (out_valid !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_clear: out_valid=%b busy=%b, required 0000/0", out_valid, busy);
    end
    $display("test_single done");
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b1, 2'd1, 8'h77, 4'h0);
    tick();
    drive(1'b0, 1'b1, 2'd1, 8'h99, 4'h0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL blocked_ready: in_ready=%b, required 0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h77) begin
      bad++;
      $display("FAIL held_slot: out_valid=%b data1=%h, required 0010/77",
               out_valid, out_data[15:8]);
    end
    drive(1'b0, 1'b1, 2'd3, 8'h3C, 4'h0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL other_slot_ready: in_ready=%b, required 1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b1010 || out_data[31:24] !== 8'h3C || out_data[15:8] !== 8'h77) begin
      bad++;
      $display("FAIL other_slot_load: out_valid=%b data3=%h data1=%h, required 1010/3c/77",
               out_valid, out_data[31:24], out_data[15:8]);
    end
    drain();
    $display("test_backpressure done");
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 2'd0, 8'h11, 4'h0);
    tick();
    drive(1'b0, 1'b1, 2'd0, 8'h22, 4'b0001);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
    end
    tick();
    total++;
    if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h22) begin
      bad++;
      $display("FAIL b2b_reload: valid0=%b data0=%h, required 1/22", out_valid[0], out_data[7:0]);
    end
    drain();
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    fill(4'b1101, 8'h40);
    drive(1'b1, 1'b1, 2'd1, 8'h55, 4'b0001);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready: in_ready=%b, required 0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b0 || drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL flush_drop: out_valid=%b drop=%0d, required 0000/2", out_valid, drop_cnt);
    end
    drain();
    $display("test_flush done");
  endtask

  task automatic test_random();
    logic       f;
    logic [3:0] ordy;
    for (int n = 0; n < 300; n++) begin
      f    = ($urandom_range(0, 15) == 0);
      ordy = 4'($urandom);
      drive(f, 1'($urandom), 2'($urandom), 8'($urandom), ordy);
      total++;
      if (in_ready !== exp_ready() || busy !== (|m_valid)) begin
        bad++;
        $display("FAIL rand_comb[%0d]: in_ready=%b busy=%b, required %b/%b",
                 n, in_ready, busy, exp_ready(), |m_valid);
      end
      tick();
      total++;
      if (out_valid !== m_valid || drop_cnt !== 8'(m_drop)) begin
        bad++;
        $display("FAIL rand_state[%0d]: out_valid=%b drop=%0d, required %b/%0d",
                 n, out_valid, drop_cnt, m_valid, m_drop);
      end
      for (int k = 0; k < 4; k++) begin
        if (m_valid[k]) begin
          total++;
          if (out_data[k*8 +: 8] !== m_data[k]) begin
            bad++;
            $display("FAIL rand_data[%0d] slot %0d: data=%h, required %h",
                     n, k, out_data[k*8 +: 8], m_data[k]);
          end
        end
      end
    end
    drain();
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    fill(4'b1111, 8'hC0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 4'b0 || out_data !== 32'd0 || drop_cnt !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: out_valid=%b data=%h drop=%0d busy=%b, required all zero",
               out_valid, out_data, drop_cnt, busy);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'd1, 8'h00, 4'h0);
    total++;
    if (in_ready !== 1'b1 || drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL after_async_reset: in_ready=%b drop=%0d, required 1/0", in_ready, drop_cnt);
    end
    tick();
    $display("test_async_reset done");
  endtask

  task automatic test_saturation();
    while (m_drop + 4 <= 254) begin
      fill(4'b1111, 8'h10);
      drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
      tick();
    end
    fill(4'((1 << (254 - m_drop)) - 1), 8'h20);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
    tick();
    total++;
    if (drop_cnt !== 8'd254) begin
      bad++;
      $display("FAIL drop_254: drop=%0d, required 254", drop_cnt);
    end
    fill(4'b0111, 8'h30);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
    tick();
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL drop_sat: drop=%0d, required 255", drop_cnt);
    end
    fill(4'b1000, 8'h40);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
    tick();
    total++;
    if (drop_cnt !== 8'd255 || out_valid !== 4'b0) begin
      bad++;
      $display("FAIL drop_hold: drop=%0d out_valid=%b, required 255/0000", drop_cnt, out_valid);
    end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
